fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of bitty_core. Holds program memory and the PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 27 ++
 rtl/instr_mem.sv | 31 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage feeding bitty_core.
package fetch_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    ADVANCE = 3'd3,
    HALTED  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Control, program-load and core handshake signals of fetch_unit.
interface fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = fetch_pkg::DATA_W
);
  logic              start;
  logic              stop;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              done;
  logic [DATA_W-1:0] instruction;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  modport master (
    output start, stop, ld_we, ld_addr, ld_data, done,
    input  instruction, run, pc, busy, halted
  );

  modport slave (
    input  start, stop, ld_we, ld_addr, ld_data, done,
    output instruction, run, pc, busy, halted
  );
endinterface

// File: rtl/instr_mem.sv
// Program memory: one synchronous write port, one synchronous write-first read port.
module instr_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // A same-cycle write to the read address is forwarded so the new word is read.
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) rdata_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, program memory and run/done handshake to bitty_core.
// Optional halt-word detection is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = fetch_pkg::DATA_W
`ifdef FETCH_HALT_EN
  , parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(fetch_pkg::HALT_WORD_DEFAULT)
`endif
) (
  input logic   clk,
  input logic   reset,
  fetch_if.slave bus
);
  import fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              stop_pend_q, stop_pend_d;
  logic              mem_we_c;
  logic              halt_hit_c;

  // Loads are only honoured while no fetch is in flight.
  assign mem_we_c = bus.ld_we && ((state_q == IDLE) || (state_q == HALTED));

`ifdef FETCH_HALT_EN
  assign halt_hit_c = (rdata == HALT_WORD);
`else
  assign halt_hit_c = 1'b0;
`endif

  // Read address is the next pc, so mem[pc] is on rdata throughout FETCH.
  instr_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_instr_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .raddr (pc_d),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) state_d = FETCH;
      end
      FETCH: begin
        stop_pend_d = stop_pend_q | bus.stop;
        if (halt_hit_c) begin
          state_d     = HALTED;
          stop_pend_d = 1'b0;
        end else begin
          instr_d = rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        stop_pend_d = stop_pend_q | bus.stop;
        if (bus.done) state_d = ADVANCE;
      end
      ADVANCE: begin
        pc_d = pc_q + ADDR_W'(1);
        if (stop_pend_q || bus.stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else begin
          state_d = FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: begin
        if (bus.start && !bus.stop) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    run_d  = (state_d == ISSUE);
    busy_d = (state_d == FETCH) || (state_d == ISSUE) || (state_d == ADVANCE);
`ifdef FETCH_HALT_EN
    halted_d = (state_d == HALTED);
`else
    halted_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.run         = run_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: model predicts the (pc, instruction) issue stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic core_done = 1'b0;
  int   cyc_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   issue_cnt = 0;
  int   last_issue_cyc = 0;
  int   last_done_cyc = 0;
  int   done_req_cnt = 0;
  int   done_ack_cnt = 0;
  bit   auto_done = 1'b0;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [AW-1:0] pc_m = '0;
  bit            halted_m = 1'b0;

  fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  assign bus.done = core_done;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    if (w == HALT_WORD_DEFAULT) w = 16'hFFFE;
    return w;
  endfunction

  // Monitor: every rising edge of run is one issued instruction.
  initial begin : monitor
    bit   prev_run;
    exp_t e;
    prev_run = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.run === 1'b1 && !prev_run) begin
        issue_cnt++;
        last_issue_cyc = cyc_n;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got pc=%0h instr=%0h expected no issue", bus.pc, bus.instruction);
        end else begin
          e = exp_q.pop_front();
          check("issue_instr", 32'(bus.instruction), 32'(e.instr));
          check("issue_pc", 32'(bus.pc), 32'(e.pc));
        end
      end
      prev_run = (bus.run === 1'b1);
    end
  end

  // Core stand-in: retires each issued instruction, automatically or on request.
  initial begin : core_resp
    forever begin
      @(negedge clk);
      if (bus.run === 1'b1 && !reset && (auto_done || (done_ack_cnt < done_req_cnt))) begin
        if (auto_done) repeat ($urandom_range(3, 1)) @(negedge clk);
        else done_ack_cnt++;
        core_done = 1'b1;
        last_done_cyc = cyc_n;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] p);
    exp_t e;
    e.pc = p; e.instr = mem_m[p];
    exp_q.push_back(e);
  endtask

  task automatic wait_issue(input int target);
    int c = 0;
    while (issue_cnt < target && c < 200) begin @(negedge clk); c++; end
    check("wait_issue", 32'(issue_cnt), 32'(target));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.busy !== 1'b0 && c < 300) begin @(negedge clk); c++; end
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_pc", 32'(bus.pc), 32'(pc_m));
    check("idle_run", 32'(bus.run), 32'd0);
  endtask

  // Run n instructions from the model pc, then stop while the last one is in ISSUE.
  task automatic run_n(input int n, input bit same_load, input bit from_halt);
    int            got = 0;
    int            target;
    int            c = 0;
    logic [AW-1:0] la = '0;
    logic [DW-1:0] ld = '0;
    if (from_halt) begin pc_m = pc_m + AW'(1); halted_m = 1'b0; end
    if (same_load) begin la = AW'($urandom); ld = rand_word(); mem_m[la] = ld; end
    for (int i = 0; i < n; i++) begin
`ifdef FETCH_HALT_EN
      if (mem_m[pc_m] == HALT_WORD_DEFAULT) begin halted_m = 1'b1; break; end
`endif
      push_exp(pc_m);
      pc_m = pc_m + AW'(1);
      got++;
    end
    target = issue_cnt + got;
    @(negedge clk);
    bus.start = 1'b1;
    if (same_load) begin bus.ld_we = 1'b1; bus.ld_addr = la; bus.ld_data = ld; end
    @(negedge clk);
    bus.start = 1'b0; bus.ld_we = 1'b0;
    if (halted_m) begin
      while (bus.halted !== 1'b1 && c < 300) begin @(negedge clk); c++; end
      check("wait_halted", 32'(bus.halted), 32'd1);
    end else begin
      wait_issue(target);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      wait_idle();
    end
  endtask

  initial begin : stimulus
    int            tgt;
    bit            any_run;
    logic [AW-1:0] a;
    bus.start = 1'b0; bus.stop = 1'b0; bus.ld_we = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #20;
    check("rst_run", 32'(bus.run), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    load(AW'(0), 16'h0448);
    load(AW'(1), 16'h2448);
    load(AW'(2), 16'h4448);
    for (int i = 3; i < int'(DEPTH); i++) load(AW'(i), rand_word());

    // Directed first transaction with explicit latency checks.
    push_exp(AW'(0));
    tgt = issue_cnt + 1;
    @(negedge clk);
    bus.start = 1'b1;
    tgt = tgt;
    begin
      int sc;
      sc = cyc_n;
      @(negedge clk);
      bus.start = 1'b0;
      wait_issue(tgt);
      check("start_latency", 32'(last_issue_cyc - sc), 32'd2);
    end

    // Load and start while in ISSUE must both be ignored.
    @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = AW'(0); bus.ld_data = 16'hAAAA; bus.start = 1'b1;
    @(negedge clk);
    bus.ld_we = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("ign_run", 32'(bus.run), 32'd1);
    check("ign_busy", 32'(bus.busy), 32'd1);
    check("ign_pc", 32'(bus.pc), 32'd0);
    check("ign_instr", 32'(bus.instruction), 32'h0448);

    push_exp(AW'(1));
    tgt = issue_cnt + 1;
    done_req_cnt++;
    wait_issue(tgt);
    check("done_latency", 32'(last_issue_cyc - last_done_cyc), 32'd3);

    // Stop in ISSUE at pc=1: instruction retires, unit goes idle at pc=2.
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    done_req_cnt++;
    pc_m = AW'(2);
    wait_idle();
    repeat (5) @(negedge clk);
    check("stop_no_pending", 32'(exp_q.size()), 32'd0);

    // Start and stop together in IDLE: stop wins.
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    check("startstop_busy", 32'(bus.busy), 32'd0);
    check("startstop_pc", 32'(bus.pc), 32'd2);

    push_exp(AW'(2));
    tgt = issue_cnt + 1;
    pulse_start();
    wait_issue(tgt);

    // Reset asserted between edges during ISSUE.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_run", 32'(bus.run), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_instr", 32'(bus.instruction), 32'd0);
    check("midrst_pc", 32'(bus.pc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc_m = '0;

    // Randomized runs; pc wraps through 15 -> 0 several times.
    auto_done = 1'b1;
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(2, 0)) load(AW'($urandom), rand_word());
      run_n(int'($urandom_range(8, 1)), bit'($urandom_range(1, 0)), 1'b0);
    end

    // Halt word: stops before issue with halt enabled, issues normally otherwise.
    a = pc_m;
    load(a, rand_word());
    load(AW'(a + AW'(1)), HALT_WORD_DEFAULT);
    load(AW'(a + AW'(2)), rand_word());
`ifdef FETCH_HALT_EN
    run_n(3, 1'b0, 1'b0);
    any_run = 1'b0;
    repeat (10) begin @(negedge clk); any_run = any_run | (bus.run === 1'b1); end
    check("halt_run_low", 32'(any_run), 32'd0);
    check("halt_pc", 32'(bus.pc), 32'(pc_m));
    check("halt_busy", 32'(bus.busy), 32'd0);
    run_n(2, 1'b0, 1'b1);
`else
    any_run = 1'b0;
    run_n(3, 1'b0, 1'b0);
    check("nohalt_halted", 32'(bus.halted), 32'(any_run));
`endif
    run_n(4, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
